pdac_multichannel_interface: RTL and testbench
==============================================

Name: pdac_multichannel_interface

Overview:
Parameterised successor to the single-channel parallel DAC write controller. It drives NCH parallel-input DACs that share one data bus and one WR strobe, with a one-hot chip-select per channel. Each channel has a one-deep pending register, and a round-robin arbiter grants the bus. Input slice position, WR pulse width, setup and settle times are all parameters. It sits between the DSP datapath (per-channel sample strobes) and the DAC board pins.

Parameters:
NCH, 4, number of DAC channels (1..8)
IN_W, 16, width of each input sample
DAC_W, 12, DAC bus width; must satisfy LSB_SEL+DAC_W <= IN_W
LSB_SEL, 2, index of input bit driven onto dac_out[0]
SETUP_CYCLES, 1, clocks that data/sel are held before WR rises (0..255)
WR_CYCLES, 1, WR high time in clocks (1..255)
SETTLE_CYCLES, 10, clocks after WR falls before completion (0..255)

Ports:
clk  in  1  system clock
reset  in  1  reset, synchronous, active-high
start  in  NCH  per-channel write request, 1-cycle pulse; bit i qualifies dac_data slice i
dac_data  in  NCH*IN_W  channel i sample in bits [i*IN_W +: IN_W]
overrun_clr  in  1  clears all overrun flags
dac_out  out  DAC_W  shared parallel DAC data bus
dac_sel  out  NCH  one-hot chip select of the channel being written; 0 when idle
wr  out  1  write strobe, high for WR_CYCLES
dac_valid  out  NCH  1-cycle pulse on bit i when channel i's write has settled
busy  out  1  high from grant through the settle phase
pending  out  NCH  channel has captured data not yet written
overrun  out  NCH  sticky: a pending sample was overwritten before it was written

Behaviour:
- Reset clears all outputs, pending data, the counter and overrun, and sets state IDLE and the round-robin pointer to channel 0. Reset mid-write drops wr and dac_sel to 0 on the next edge. dac_out resets to 0.
- Capture: start[i]=1 loads pending_data[i] (IN_W bits) and sets pending[i] on that edge.
  - If pending[i] was already set and channel i is not granted on the same edge, the data is overwritten (latest wins) and overrun[i] is set.
  - If channel i is granted on the same edge, the new sample becomes pending with no overrun.
- overrun_clr clears all overrun bits. A simultaneous new overrun event wins (the bit stays set).
- Data mapping: dac_out = pending_data[ch][LSB_SEL+DAC_W-1:LSB_SEL], an unsigned truncation (see Optional Feature).
- FSM states: IDLE, SETUP, WRITE, SETTLE, DONE.
  - IDLE: busy=0, wr=0. If any pending bit is set, grant the first set channel searching from rr_ptr upward with wrap-around. On the grant edge: load dac_out, set dac_sel=onehot(ch), clear pending[ch], busy=1, rr_ptr=ch+1 mod NCH. Go to SETUP, or to WRITE if SETUP_CYCLES=0.
  - SETUP: wr=0, held SETUP_CYCLES clocks, then WRITE.
  - WRITE: wr=1 for exactly WR_CYCLES clocks, then SETTLE, or DONE if SETTLE_CYCLES=0.
  - SETTLE: wr=0, dac_sel held, lasts SETTLE_CYCLES clocks, then DONE.
  - DONE: lasts one cycle. dac_valid[ch]=1, dac_sel=0, busy=0, wr=0. Always returns to IDLE, so there is at least one idle cycle between writes.
- dac_out and dac_sel are stable for the whole SETUP/WRITE/SETTLE window. dac_out holds its last value in IDLE.
- Latency: with start sampled at edge 0 and the bus free, dac_valid is high in the cycle after edge 2+SETUP_CYCLES+WR_CYCLES+SETTLE_CYCLES. The defaults give 14.
- Phase timing uses one 8-bit down-counter.
- Idle cost: the block returns through DONE and IDLE before the next grant. A channel with a continuous backlog waits at most NCH-1 other writes.

Optional Feature:
Macro PDAC_SATURATE_EN.
- Defined: if any input bit above the slice (bits IN_W-1 .. LSB_SEL+DAC_W) is 1, dac_out becomes all ones instead of the truncated value. If LSB_SEL+DAC_W == IN_W there are no upper bits and the output is unchanged. The decision is made on the grant edge.
- Undefined: plain truncation. No extra logic is generated.

Test Plan:
- Single write, defaults: start=4'b0001, dac_data[15:0]=16'h1234 -> on the grant edge dac_out=12'h48D and dac_sel=0001. wr is high for 1 cycle, 2 cycles after grant. dac_valid=0001 for 1 cycle, 14 cycles after start. busy stays high from grant until that dac_valid cycle.
- Round-robin: start=4'b1111 in one cycle with distinct data -> writes occur in channel order 0,1,2,3. Each channel's dac_out matches its slice. There are four dac_valid pulses, and each write is separated by the idle cycle.
- Overrun: start[2] with data 16'h0004, then start[2] with 16'h0008 while channel 0 is busy -> channel 2 writes 12'h002 and overrun[2]=1. After overrun_clr, overrun=0.
- Parameter sweep: SETUP=0, WR=3, SETTLE=0 -> wr rises on the grant edge's next cycle and stays high 3 cycles. dac_valid follows immediately, at latency 2+0+3+0=5.
- Reset mid-write: assert reset during SETTLE -> next cycle wr=0, dac_sel=0, busy=0, pending=0, and no dac_valid pulse.
- With PDAC_SATURATE_EN: dac_data=16'hC000 -> dac_out=12'hFFF. Without it: dac_out=12'h000.

Source files
------------

// File: rtl/pdac_multichannel_interface.sv
// Multi-channel parallel DAC write controller: per-channel pending registers, round-robin bus arbiter,
// setup/write/settle sequencing. Optional macro PDAC_SATURATE_EN saturates out-of-range samples.
module pdac_multichannel_interface #(
    parameter int unsigned NCH           = 4,
    parameter int unsigned IN_W          = 16,
    parameter int unsigned DAC_W         = 12,
    parameter int unsigned LSB_SEL       = 2,
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned WR_CYCLES     = 1,
    parameter int unsigned SETTLE_CYCLES = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NCH-1:0]        start,
    input  logic [NCH*IN_W-1:0]   dac_data,
    input  logic                  overrun_clr,
    output logic [DAC_W-1:0]      dac_out,
    output logic [NCH-1:0]        dac_sel,
    output logic                  wr,
    output logic [NCH-1:0]        dac_valid,
    output logic                  busy,
    output logic [NCH-1:0]        pending,
    output logic [NCH-1:0]        overrun
);

    localparam int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {IDLE, SETUP, WRITE, SETTLE, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CH_W-1:0]    cur_ch_q, cur_ch_d;
    logic [CH_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [DAC_W-1:0]   pend_slice [NCH];

    logic [DAC_W-1:0]   dac_out_d;
    logic [NCH-1:0]     dac_sel_d;
    logic               wr_d;
    logic [NCH-1:0]     dac_valid_d;
    logic               busy_d;
    logic [NCH-1:0]     pending_d;
    logic [NCH-1:0]     overrun_d;

    logic               found;
    logic               grant;
    logic [CH_W-1:0]    gch;
    logic [NCH-1:0]     grant_vec;
    logic [NCH-1:0]     ov_ev;

    // Sample bits outside the DAC slice only matter for the saturation decision.
    logic unused_data;
    assign unused_data = ^dac_data;

`ifdef PDAC_SATURATE_EN
    localparam logic [IN_W-1:0] SAT_ONE    = IN_W'(1);
    localparam logic [IN_W-1:0] UPPER_MASK = ~((SAT_ONE << (LSB_SEL + DAC_W)) - SAT_ONE);
    logic [NCH-1:0] pend_hi;
`endif

    // Round-robin search: first pending channel at or above rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        gch   = '0;
        for (int k = 0; k < NCH; k++) begin
            if (!found && pending[(int'(rr_ptr_q) + k) % NCH]) begin
                found = 1'b1;
                gch   = CH_W'((int'(rr_ptr_q) + k) % NCH);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cur_ch_d    = cur_ch_q;
        rr_ptr_d    = rr_ptr_q;
        dac_out_d   = dac_out;
        dac_sel_d   = dac_sel;
        busy_d      = busy;
        grant       = 1'b0;
        wr_d        = (state_q == WRITE);
        dac_valid_d = (state_q == DONE) ? (NCH'(1) << cur_ch_q) : '0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant     = 1'b1;
                    cur_ch_d  = gch;
                    rr_ptr_d  = (gch == CH_W'(NCH - 1)) ? '0 : CH_W'(gch + 1'b1);
`ifdef PDAC_SATURATE_EN
                    dac_out_d = pend_hi[gch] ? '1 : pend_slice[gch];
`else
                    dac_out_d = pend_slice[gch];
`endif
                    dac_sel_d = NCH'(1) << gch;
                    busy_d    = 1'b1;
                    if (SETUP_CYCLES > 0) begin
                        state_d = SETUP;
                        cnt_d   = CNT_W'(SETUP_CYCLES - 1);
                    end else begin
                        state_d = WRITE;
                        cnt_d   = CNT_W'(WR_CYCLES - 1);
                    end
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = WRITE;
                    cnt_d   = CNT_W'(WR_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WRITE: begin
                if (cnt_q == '0) begin
                    if (SETTLE_CYCLES > 0) begin
                        state_d = SETTLE;
                        cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d   = IDLE;
                dac_sel_d = '0;
                busy_d    = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // A granted channel re-captured on the grant edge is fresh data, not an overrun.
        grant_vec = grant ? (NCH'(1) << gch) : '0;
        ov_ev     = start & pending & ~grant_vec;
        pending_d = start | (pending & ~grant_vec);
        overrun_d = (overrun & ~{NCH{overrun_clr}}) | ov_ev;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cur_ch_q  <= '0;
            rr_ptr_q  <= '0;
            dac_out   <= '0;
            dac_sel   <= '0;
            wr        <= 1'b0;
            dac_valid <= '0;
            busy      <= 1'b0;
            pending   <= '0;
            overrun   <= '0;
            for (int i = 0; i < NCH; i++) pend_slice[i] <= '0;
`ifdef PDAC_SATURATE_EN
            pend_hi   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_ch_q  <= cur_ch_d;
            rr_ptr_q  <= rr_ptr_d;
            dac_out   <= dac_out_d;
            dac_sel   <= dac_sel_d;
            wr        <= wr_d;
            dac_valid <= dac_valid_d;
            busy      <= busy_d;
            pending   <= pending_d;
            overrun   <= overrun_d;
            for (int i = 0; i < NCH; i++) begin
                if (start[i]) begin
                    pend_slice[i] <= dac_data[i*IN_W + LSB_SEL +: DAC_W];
`ifdef PDAC_SATURATE_EN
                    pend_hi[i]    <= |(dac_data[i*IN_W +: IN_W] & UPPER_MASK);
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_pdac_multichannel_interface.sv
// Bench for pdac_multichannel_interface: directed vector table, hand sequences, and randomized
// traffic checked against a transaction-level model for a default and a short-timing instance.
module tb_pdac_multichannel_interface;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  start;
    logic [63:0] dac_data;
    logic        overrun_clr;

    logic [11:0] dac_out,   dac_out2;
    logic [3:0]  dac_sel,   dac_sel2;
    logic        wr,        wr2;
    logic [3:0]  dac_valid, dac_valid2;
    logic        busy,      busy2;
    logic [3:0]  pending,   pending2;
    logic [3:0]  overrun,   overrun2;

    int passed = 0;
    int total  = 0;

    pdac_multichannel_interface #(
        .NCH(4), .IN_W(16), .DAC_W(12), .LSB_SEL(2),
        .SETUP_CYCLES(1), .WR_CYCLES(1), .SETTLE_CYCLES(10)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .dac_data(dac_data), .overrun_clr(overrun_clr),
        .dac_out(dac_out), .dac_sel(dac_sel), .wr(wr), .dac_valid(dac_valid),
        .busy(busy), .pending(pending), .overrun(overrun)
    );

    pdac_multichannel_interface #(
        .NCH(4), .IN_W(16), .DAC_W(12), .LSB_SEL(2),
        .SETUP_CYCLES(0), .WR_CYCLES(3), .SETTLE_CYCLES(0)
    ) dut2 (
        .clk(clk), .reset(reset), .start(start), .dac_data(dac_data), .overrun_clr(overrun_clr),
        .dac_out(dac_out2), .dac_sel(dac_sel2), .wr(wr2), .dac_valid(dac_valid2),
        .busy(busy2), .pending(pending2), .overrun(overrun2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- reference model (per instance m) ----------------
    function automatic int p_s(input int m); return (m == 0) ? 1 : 0;  endfunction
    function automatic int p_w(input int m); return (m == 0) ? 1 : 3;  endfunction
    function automatic int p_t(input int m); return (m == 0) ? 10 : 0; endfunction

    function automatic logic [11:0] ref_map(input logic [15:0] x);
`ifdef PDAC_SATURATE_EN
        if (x >= 16'h4000) return 12'hFFF;
`endif
        return 12'((x / 16'd4) % 16'd4096);
    endfunction

    longint      n_edge = 0;
    bit          m_pend [2][4];
    logic [15:0] m_data [2][4];
    bit          m_ovr  [2][4];
    int          m_rr   [2];
    bit          m_have [2];
    longint      m_g    [2];
    int          m_ch   [2];
    logic [11:0] m_val  [2];

    logic        s_rst, s_clr;
    logic [3:0]  s_start;
    logic [63:0] s_data;

    task automatic model_step(input int m);
        int c;
        bit ev;
        if (s_rst) begin
            for (int i = 0; i < 4; i++) begin m_pend[m][i] = 0; m_ovr[m][i] = 0; end
            m_have[m] = 0; m_val[m] = '0; m_rr[m] = 0;
            return;
        end
        // Bus is free once the previous write's valid cycle has passed.
        if (!m_have[m] || n_edge >= m_g[m] + p_s(m) + p_w(m) + p_t(m) + 2) begin
            c = -1;
            for (int k = 0; k < 4; k++)
                if (c < 0 && m_pend[m][(m_rr[m] + k) % 4]) c = (m_rr[m] + k) % 4;
            if (c >= 0) begin
                m_have[m] = 1; m_g[m] = n_edge; m_ch[m] = c;
                m_val[m] = ref_map(m_data[m][c]);
                m_rr[m] = (c + 1) % 4;
                m_pend[m][c] = 0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            ev = s_start[i] && m_pend[m][i];
            if (s_start[i]) begin m_pend[m][i] = 1; m_data[m][i] = s_data[i*16 +: 16]; end
            m_ovr[m][i] = (m_ovr[m][i] && !s_clr) || ev;
        end
    endtask

    task automatic check_outputs(input int m);
        longint rel;
        int d;
        logic [3:0] oh, e_sel, e_val, e_pend, e_ovr;
        logic e_wr, e_busy;
        d   = p_s(m) + p_w(m) + p_t(m);
        rel = n_edge - m_g[m];
        oh  = 4'(1) << m_ch[m];
        e_busy = m_have[m] && rel <= d;
        e_sel  = e_busy ? oh : 4'h0;
        e_wr   = m_have[m] && rel >= p_s(m) + 1 && rel <= p_s(m) + p_w(m);
        e_val  = (m_have[m] && rel == d + 1) ? oh : 4'h0;
        for (int i = 0; i < 4; i++) begin e_pend[i] = m_pend[m][i]; e_ovr[i] = m_ovr[m][i]; end
        chk($sformatf("i%0d_out", m),     32'(m == 0 ? dac_out : dac_out2),     32'(m_val[m]));
        chk($sformatf("i%0d_sel", m),     32'(m == 0 ? dac_sel : dac_sel2),     32'(e_sel));
        chk($sformatf("i%0d_wr", m),      32'(m == 0 ? wr : wr2),               32'(e_wr));
        chk($sformatf("i%0d_valid", m),   32'(m == 0 ? dac_valid : dac_valid2), 32'(e_val));
        chk($sformatf("i%0d_busy", m),    32'(m == 0 ? busy : busy2),           32'(e_busy));
        chk($sformatf("i%0d_pending", m), 32'(m == 0 ? pending : pending2),     32'(e_pend));
        chk($sformatf("i%0d_overrun", m), 32'(m == 0 ? overrun : overrun2),     32'(e_ovr));
    endtask

    always @(posedge clk) begin
        s_rst = reset; s_clr = overrun_clr; s_start = start; s_data = dac_data;
        n_edge++;
        model_step(0);
        model_step(1);
        #1;
        check_outputs(0);
        check_outputs(1);
    end

    // ---------------- directed stimulus ----------------
    typedef struct {
        int          ch;
        logic [15:0] data;
        logic [11:0] exp_out;
    } vec_t;

    vec_t vecs [6];

    task automatic do_reset();
        @(negedge clk); reset = 1'b1; start = '0; overrun_clr = 1'b0;
        @(negedge clk); @(negedge clk); reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic single_write(input vec_t v);
        logic [3:0] oh;
        oh = 4'(1) << v.ch;
        @(negedge clk); dac_data[v.ch*16 +: 16] = v.data; start = oh;
        @(negedge clk); start = '0;                                   // after edge 0
        @(negedge clk);                                               // edge 1: grant
        chk("grant_out",  32'(dac_out), 32'(v.exp_out));
        chk("grant_sel",  32'(dac_sel), 32'(oh));
        chk("grant_busy", 32'(busy), 32'd1);
        @(negedge clk);                                               // edge 2
        chk("wr_early", 32'(wr), 32'd0);
        chk("sw_wr_rise", 32'(wr2), 32'd1);
        @(negedge clk);                                               // edge 3
        chk("wr_pulse", 32'(wr), 32'd1);
        @(negedge clk);                                               // edge 4
        chk("wr_end", 32'(wr), 32'd0);
        chk("sw_wr_hold", 32'(wr2), 32'd1);
        @(negedge clk);                                               // edge 5
        chk("sw_valid", 32'(dac_valid2), 32'(oh));
        chk("sw_wr_fall", 32'(wr2), 32'd0);
        repeat (8) @(negedge clk);                                    // edge 13
        chk("valid_early", 32'(dac_valid), 32'd0);
        chk("busy_settle", 32'(busy), 32'd1);
        @(negedge clk);                                               // edge 14
        chk("valid", 32'(dac_valid), 32'(oh));
        chk("busy_done", 32'(busy), 32'd0);
        chk("sel_done", 32'(dac_sel), 32'd0);
        @(negedge clk);
        chk("valid_once", 32'(dac_valid), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic round_robin();
        logic [15:0] rd [4];
        logic [11:0] re [4];
        int vcount;
        rd = '{16'h0100, 16'h0204, 16'h0408, 16'h080C};
        re = '{12'h040, 12'h081, 12'h102, 12'h203};
        vcount = 0;
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 4; i++) dac_data[i*16 +: 16] = rd[i];
        start = 4'hF;
        @(negedge clk); start = '0;
        for (int e = 1; e <= 58; e++) begin
            @(negedge clk);
            if (dac_valid != 4'h0) vcount++;
            if ((e - 1) % 14 == 0 && e <= 43) begin
                chk($sformatf("rr_sel%0d", (e - 1) / 14), 32'(dac_sel), 32'(4'(1) << ((e - 1) / 14)));
                chk($sformatf("rr_out%0d", (e - 1) / 14), 32'(dac_out), 32'(re[(e - 1) / 14]));
            end
            if (e == 14) chk("rr_gap", 32'(dac_sel), 32'd0);
        end
        chk("rr_valid_count", 32'(vcount), 32'd4);
    endtask

    task automatic overrun_seq();
        do_reset();
        @(negedge clk); dac_data[15:0] = 16'h1111; start = 4'b0001;
        @(negedge clk); dac_data[47:32] = 16'h0004; start = 4'b0100;   // after edge 0
        @(negedge clk); dac_data[47:32] = 16'h0008;                    // after edge 1
        @(negedge clk); start = '0;                                    // after edge 2
        chk("ovr_set", 32'(overrun), 32'h4);
        chk("ovr_pending", 32'(pending), 32'h4);
        repeat (13) @(negedge clk);                                    // edge 15
        chk("ovr_out", 32'(dac_out), 32'h002);
        chk("ovr_sel", 32'(dac_sel), 32'h4);
        overrun_clr = 1'b1;
        @(negedge clk); overrun_clr = 1'b0;
        chk("ovr_clr", 32'(overrun), 32'h0);
        // A new overrun on the same edge as overrun_clr must survive.
        start = 4'b0001;
        @(negedge clk); start = 4'b0100;
        @(negedge clk); overrun_clr = 1'b1;
        @(negedge clk); start = '0; overrun_clr = 1'b0;
        chk("ovr_clr_race", 32'(overrun), 32'h4);
        repeat (40) @(negedge clk);
    endtask

    task automatic reset_mid_write();
        do_reset();
        @(negedge clk); dac_data[31:16] = 16'h1234; start = 4'b0010;
        @(negedge clk); start = '0;                                    // after edge 0
        repeat (5) @(negedge clk);                                     // after edge 5
        start = 4'b1000;
        @(negedge clk); start = '0;                                    // after edge 6
        chk("pre_rst_pend", 32'(pending), 32'h8);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;                                  // after edge 7
        chk("rst_wr", 32'(wr), 32'd0);
        chk("rst_sel", 32'(dac_sel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("rst_no_valid", 32'(dac_valid), 32'd0);
        end
    endtask

    task automatic random_traffic(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                dac_data[i*16 +: 16] = 16'($urandom);
                if ($urandom_range(0, 1) == 0) dac_data[i*16 + 14 +: 2] = 2'b00;
            end
            start       = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            overrun_clr = ($urandom_range(0, 19) == 0);
            reset       = ($urandom_range(0, 399) == 0);
        end
        @(negedge clk); start = '0; overrun_clr = 1'b0; reset = 1'b0;
        repeat (80) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{ch: 0, data: 16'h1234, exp_out: 12'h48D};
        vecs[1] = '{ch: 1, data: 16'hFFFF, exp_out: 12'hFFF};
        vecs[2] = '{ch: 2, data: 16'h0004, exp_out: 12'h001};
        vecs[3] = '{ch: 3, data: 16'h3FFC, exp_out: 12'hFFF};
`ifdef PDAC_SATURATE_EN
        vecs[4] = '{ch: 3, data: 16'hC000, exp_out: 12'hFFF};
        vecs[5] = '{ch: 1, data: 16'h8003, exp_out: 12'hFFF};
`else
        vecs[4] = '{ch: 3, data: 16'hC000, exp_out: 12'h000};
        vecs[5] = '{ch: 1, data: 16'h8003, exp_out: 12'h000};
`endif

        reset = 1'b1; start = '0; dac_data = '0; overrun_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_out",     32'(dac_out),   32'd0);
        chk("reset_sel",     32'(dac_sel),   32'd0);
        chk("reset_wr",      32'(wr),        32'd0);
        chk("reset_valid",   32'(dac_valid), 32'd0);
        chk("reset_busy",    32'(busy),      32'd0);
        chk("reset_pending", 32'(pending),   32'd0);
        chk("reset_overrun", 32'(overrun),   32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) single_write(vecs[i]);
        round_robin();
        overrun_seq();
        reset_mid_write();
        random_traffic(1500);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
